// File: rtl/multibyte_add_seq.sv
// Byte-serial W-bit adder sequencer around an external 8-bit CLA slice.
// Ports: in_* operand handshake, add_* slice drive/capture, out_* result.
// Optional subtract mode: define SEQ_ADD_SUB_EN.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_ci,
  input  logic                  op_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_ci,
  input  logic [7:0]            add_s,
  input  logic                  add_co,
  input  logic                  add_of,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  carry,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          cr_q, cr_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          last;

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign last      = (idx_q == IW'(NBYTES - 1));

`ifndef SEQ_ADD_SUB_EN
  logic unused_sub;
  assign unused_sub = op_sub;
`endif

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = a_q[8*idx_q +: 8];
      add_b  = b_q[8*idx_q +: 8];
      add_ci = cr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cr_d    = cr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          cr_d    = op_ci;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef SEQ_ADD_SUB_EN
          // a - b = a + ~b + 1
          if (op_sub) begin
            b_d  = ~op_b;
            cr_d = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        acc_d[8*idx_q +: 8] = add_s;
        cr_d = add_co;
        if (last) begin
          // Result registers update only on completion so the
          // previous result stays visible while a new add runs.
          sum_d   = acc_d;
          carry_d = add_co;
          ovf_d   = add_of;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq with a behavioural 8-bit slice.
// Directed vectors; monitor pops expected results on out handshakes.
module tb_multibyte_add_seq;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] op_a, op_b;
  logic        op_ci, op_sub;
  logic [7:0]  add_a, add_b, add_s;
  logic        add_ci, add_co, add_of;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        carry, overflow, busy;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_ci(op_ci), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co), .add_of(add_of),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slice model: 8-bit add, carry out, signed overflow.
  always_comb begin
    {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};
    add_of = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
  end

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] tr_a[NB];
  logic [7:0] tr_b[NB];
  logic       tr_c[NB];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got sum %h want none", sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", sum, mon_e.s);
        chk("carry", {31'd0, carry}, {31'd0, mon_e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, mon_e.o});
      end
    end
  end

  task automatic run_op(input string nm, input logic [31:0] a,
                        input logic [31:0] b, input logic ci,
                        input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo, input int bp);
    int lat;
    @(negedge clk);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; op_ci = ci; op_sub = sub; in_valid = 1'b1;
    exp_q.push_back('{s: es, c: ec, o: eo});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D; op_ci = ~ci;
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < NB) begin
        tr_a[k] = add_a; tr_b[k] = add_b; tr_c[k] = add_ci;
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, lat, NB);
    if (bp > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk({nm, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_bp_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_bp_sum"}, sum, es);
        chk({nm, "_bp_flags"}, {30'd0, carry, overflow}, {30'd0, ec, eo});
        @(posedge clk);
        #1;
        in_valid = (i < bp - 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (!out_valid) break;
    end
    chk({nm, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ov_seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_ci = 1'b0; op_sub = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_ctrl", {28'd0, out_valid, busy, carry, overflow}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_add", {23'd0, add_a, add_ci}, 32'd0);
    chk("rst_add_b", {24'd0, add_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("byte_carry", 32'h000000FF, 32'h00000001, 1'b0, 1'b0,
           32'h00000100, 1'b0, 1'b0, 0);
    run_op("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
           32'h00000000, 1'b1, 1'b0, 0);
    run_op("sovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
           32'h80000000, 1'b0, 1'b1, 0);
    run_op("mixed", 32'h12345678, 32'h0000FFFF, 1'b1, 1'b0,
           32'h12355678, 1'b0, 1'b0, 0);
    chk("tr0", {15'd0, tr_a[0], tr_b[0], tr_c[0]}, {15'd0, 8'h78, 8'hFF, 1'b1});
    chk("tr1", {15'd0, tr_a[1], tr_b[1], tr_c[1]}, {15'd0, 8'h56, 8'hFF, 1'b1});
    chk("tr2", {15'd0, tr_a[2], tr_b[2], tr_c[2]}, {15'd0, 8'h34, 8'h00, 1'b1});
    chk("tr3", {15'd0, tr_a[3], tr_b[3], tr_c[3]}, {15'd0, 8'h12, 8'h00, 1'b0});
    chk("idle_add", {23'd0, add_a, add_ci}, 32'd0);

    run_op("backpress", 32'h80000000, 32'h80000000, 1'b0, 1'b0,
           32'h00000000, 1'b1, 1'b1, 3);

`ifdef SEQ_ADD_SUB_EN
    run_op("sub_neg", 32'h00000005, 32'h00000007, 1'b0, 1'b1,
           32'hFFFFFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1,
           32'h7FFFFFFF, 1'b1, 1'b1, 0);
    run_op("sub_off", 32'h00000005, 32'h00000007, 1'b1, 1'b0,
           32'h0000000D, 1'b0, 1'b0, 0);
`else
    run_op("sub_ign", 32'h00000005, 32'h00000007, 1'b0, 1'b1,
           32'h0000000C, 1'b0, 1'b0, 0);
`endif

    // Leave a nonzero result, then reset mid-operation.
    run_op("pre_rst", 32'h11111111, 32'h22222222, 1'b0, 1'b0,
           32'h33333333, 1'b0, 1'b0, 0);
    @(negedge clk);
    op_a = 32'h01020304; op_b = 32'h01010101; op_ci = 1'b0;
    op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {27'd0, in_ready, out_valid, busy, carry, overflow},
        32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_add", {15'd0, add_a, add_b, add_ci}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    ov_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid || busy) ov_seen = 1'b1;
    end
    chk("post_rst_no_out", {31'd0, ov_seen}, 32'd0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
